// File: rtl/mem_stage_dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared definitions for the MEM-stage data cache:
//               RISC-V funct3 load/store encodings, the cache FSM state
//               type, and helpers for byte-lane selection, load extraction,
//               store replication and alignment checking.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Load encodings (funct3)
  localparam logic [2:0] LS_LB  = 3'b000;
  localparam logic [2:0] LS_LH  = 3'b001;
  localparam logic [2:0] LS_LW  = 3'b010;
  localparam logic [2:0] LS_LBU = 3'b100;
  localparam logic [2:0] LS_LHU = 3'b101;
  // Store encodings (funct3)
  localparam logic [2:0] LS_SB  = 3'b000;
  localparam logic [2:0] LS_SH  = 3'b001;
  localparam logic [2:0] LS_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_REFILL    = 2'd2
  } dc_state_t;

  // Byte enables for a store. Halfword uses addr[1] only, so addr[0] is
  // effectively masked; a word store ignores both low bits.
  function automatic logic [3:0] store_be(input logic [2:0] op, input logic [1:0] lo);
    logic [3:0] be;
    case (op)
      LS_SB:   be = 4'b0001 << lo;
      LS_SH:   be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data onto every lane it may land in.
  function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] wd);
    logic [31:0] d;
    case (op)
      LS_SB:   d = {4{wd[7:0]}};
      LS_SH:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // Select and extend the loaded lane from a 32-bit cache word.
  function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] lo,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (op)
      LS_LB:   r = {{24{b[7]}}, b};
      LS_LBU:  r = {24'h0, b};
      LS_LH:   r = {{16{h[15]}}, h};
      LS_LHU:  r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Natural-alignment violation for halfword and word accesses.
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lo);
    logic m;
    case (op)
      LS_LH, LS_LHU: m = lo[0];
      LS_LW:         m = (lo != 2'b00);
      default:       m = 1'b0;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_dcache_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_dcache_if
// Description : Word-wide request/acknowledge external memory bus.
//               master = cache side, slave = memory side.
//   MemReq       : transfer request
//   MemWb        : 1 = write, 0 = read
//   MemAddr      : word-aligned address
//   MemWriteData : write-back word
//   MemData      : read word, valid when MemAck = 1
//   MemAck       : completes the current word (may coincide with MemReq)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_dcache_if;
  logic        MemReq;
  logic        MemWb;
  logic [31:0] MemAddr;
  logic [31:0] MemWriteData;
  logic [31:0] MemData;
  logic        MemAck;

  modport master (
    output MemReq, MemWb, MemAddr, MemWriteData,
    input  MemData, MemAck
  );

  modport slave (
    input  MemReq, MemWb, MemAddr, MemWriteData,
    output MemData, MemAck
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage_dcache_array.sv
`default_nettype none
// ============================================================================
// Module      : dcache_array
// Description : Storage for the direct-mapped data cache: per-line valid,
//               dirty and tag plus data words. Asynchronous reads, a
//               synchronous byte-enabled write port, synchronous clear of
//               valid/dirty on reset. Data and tags are not reset.
// Ports       : clk, rst (sync, active-low)
//               index          - line selected for all reads/writes
//               rd_word/rd_data - access word read
//               wb_word/wb_data - write-back word read
//               line_valid/line_dirty/line_tag - selected line status
//               wr_en/wr_word/wr_be/wr_data    - data word write
//               set_dirty      - mark selected line dirty (store hit)
//               fill_done/fill_tag - install tag, valid=1, dirty=0
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_array #(
  parameter int NUM_LINES      = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int TAG_W          = 22,
  parameter int IDX_W          = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1,
  parameter int K_W            = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] index,
  input  logic [K_W-1:0]   rd_word,
  input  logic [K_W-1:0]   wb_word,
  output logic [31:0]      rd_data,
  output logic [31:0]      wb_data,
  output logic             line_valid,
  output logic             line_dirty,
  output logic [TAG_W-1:0] line_tag,
  input  logic             wr_en,
  input  logic [K_W-1:0]   wr_word,
  input  logic [3:0]       wr_be,
  input  logic [31:0]      wr_data,
  input  logic             set_dirty,
  input  logic             fill_done,
  input  logic [TAG_W-1:0] fill_tag
);

  logic [31:0]      r_data [NUM_LINES][WORDS_PER_LINE];
  logic [TAG_W-1:0] r_tag  [NUM_LINES];
  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;

  assign rd_data    = r_data[index][rd_word];
  assign wb_data    = r_data[index][wb_word];
  assign line_valid = r_valid[index];
  assign line_dirty = r_dirty[index];
  assign line_tag   = r_tag[index];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) r_data[index][wr_word][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    if (fill_done) r_tag[index] <= fill_tag;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (fill_done) begin
        r_valid[index] <= 1'b1;
        r_dirty[index] <= 1'b0;
      end else if (set_dirty) begin
        r_dirty[index] <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_dcache.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_dcache
// Description : MEM pipeline stage with a direct-mapped, write-back,
//               write-allocate data cache. Hits complete with no added
//               cycles; misses stall upstream via DStall while the victim
//               is written back (if dirty) and the line is refilled one
//               word per MemAck.
// Ports       : clk, rst (sync, active-low)
//               AluResult, WriteData, MemRead, MemWrite, LS_op - from EX
//               Result  - extended load data or AluResult
//               DStall  - freeze upstream stages
//               MisalignErr - only when MEM_MISALIGN_TRAP_EN is defined
//               mem     - external memory bus (master modport)
// Config      : `define MEM_MISALIGN_TRAP_EN to flag misaligned accesses
//               instead of masking the low address bits.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_dcache
  import mem_pkg::*;
#(
  parameter int NUM_LINES      = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] AluResult,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  LS_op,
  output logic [31:0] Result,
  output logic        DStall,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        MisalignErr,
`endif
  mem_stage_dcache_if.master mem
);

  localparam int WORD_BITS  = $clog2(WORDS_PER_LINE);
  localparam int IDX_BITS   = $clog2(NUM_LINES);
  localparam int TAG_W      = 32 - 2 - WORD_BITS - IDX_BITS;
  localparam int K_W        = (WORD_BITS == 0) ? 1 : WORD_BITS;
  localparam int LINE_BYTES = 4 * WORDS_PER_LINE;
  localparam logic [K_W-1:0] C_LAST = K_W'(WORDS_PER_LINE - 1);

  // Address split; shifts keep a zero-width word field legal.
  logic [K_W-1:0]      w_word;
  logic [IDX_BITS-1:0] w_index;
  logic [TAG_W-1:0]    w_tag;
  assign w_word  = K_W'((AluResult >> 2) & 32'(WORDS_PER_LINE - 1));
  assign w_index = IDX_BITS'(AluResult >> (2 + WORD_BITS));
  assign w_tag   = TAG_W'(AluResult >> (2 + WORD_BITS + IDX_BITS));

  dc_state_t        r_state;
  logic [K_W-1:0]   r_k;
  logic             r_req;
  logic             r_wb;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;

  logic             line_valid, line_dirty;
  logic [TAG_W-1:0] line_tag;
  logic [31:0]      rd_data, wb_data;
  logic [K_W-1:0]   w_wb_word;

  logic w_is_load, w_is_store, w_misalign;
  logic w_load, w_store, w_access, w_hit, w_idle, w_store_hit, w_refill_ack;
  logic w_arr_we, w_fill_done;
  logic [K_W-1:0] w_arr_word;
  logic [3:0]     w_arr_be;
  logic [31:0]    w_arr_data;
  logic [31:0]    w_miss_base, w_victim_base;

  assign w_is_load  = MemRead & ~MemWrite;
  assign w_is_store = MemWrite & ~MemRead;

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misalign  = (w_is_load | w_is_store) & misaligned(LS_op, AluResult[1:0]);
  assign MisalignErr = w_misalign;
`else
  assign w_misalign  = 1'b0;
`endif

  assign w_load   = w_is_load & ~w_misalign;
  assign w_store  = w_is_store & ~w_misalign;
  assign w_access = w_load | w_store;
  assign w_hit    = line_valid & (line_tag == w_tag);
  assign w_idle   = (r_state == ST_IDLE);

  // Burst states stall regardless of inputs; in IDLE only a miss stalls.
  assign DStall = ~w_idle | (w_access & ~w_hit);
  assign Result = (w_load & w_idle & w_hit) ? load_extract(LS_op, AluResult[1:0], rd_data)
                                            : AluResult;

  assign w_miss_base   = AluResult & ~32'(LINE_BYTES - 1);
  assign w_victim_base = (32'(line_tag) << (2 + WORD_BITS + IDX_BITS)) |
                         (32'(w_index) << (2 + WORD_BITS));

  // Write-back data is registered, so the array is read one word ahead:
  // word 0 when leaving IDLE, then word k+1 on each acknowledge.
  assign w_wb_word = (w_idle || r_k == C_LAST) ? '0 : r_k + K_W'(1);

  assign w_store_hit  = rst & w_store & w_idle & w_hit;
  assign w_refill_ack = rst & (r_state == ST_REFILL) & mem.MemAck;
  assign w_fill_done  = w_refill_ack & (r_k == C_LAST);

  always_comb begin
    w_arr_we   = 1'b0;
    w_arr_word = w_word;
    w_arr_be   = 4'b0000;
    w_arr_data = 32'h0;
    if (w_refill_ack) begin
      w_arr_we   = 1'b1;
      w_arr_word = r_k;
      w_arr_be   = 4'b1111;
      w_arr_data = mem.MemData;
    end else if (w_store_hit) begin
      w_arr_we   = 1'b1;
      w_arr_be   = store_be(LS_op, AluResult[1:0]);
      w_arr_data = store_data(LS_op, WriteData);
    end
  end

  dcache_array #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .TAG_W          (TAG_W),
    .IDX_W          (IDX_BITS),
    .K_W            (K_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .index      (w_index),
    .rd_word    (w_word),
    .wb_word    (w_wb_word),
    .rd_data    (rd_data),
    .wb_data    (wb_data),
    .line_valid (line_valid),
    .line_dirty (line_dirty),
    .line_tag   (line_tag),
    .wr_en      (w_arr_we),
    .wr_word    (w_arr_word),
    .wr_be      (w_arr_be),
    .wr_data    (w_arr_data),
    .set_dirty  (w_store_hit),
    .fill_done  (w_fill_done),
    .fill_tag   (w_tag)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_req   <= 1'b0;
      r_wb    <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_access && !w_hit) begin
            r_k   <= '0;
            r_req <= 1'b1;
            if (line_valid && line_dirty) begin
              r_state <= ST_WRITEBACK;
              r_wb    <= 1'b1;
              r_addr  <= w_victim_base;
              r_wdata <= wb_data;
            end else begin
              r_state <= ST_REFILL;
              r_wb    <= 1'b0;
              r_addr  <= w_miss_base;
            end
          end
        end
        ST_WRITEBACK: begin
          if (mem.MemAck) begin
            if (r_k == C_LAST) begin
              r_state <= ST_REFILL;
              r_k     <= '0;
              r_wb    <= 1'b0;
              r_addr  <= w_miss_base;
            end else begin
              r_k     <= r_k + K_W'(1);
              r_addr  <= r_addr + 32'd4;
              r_wdata <= wb_data;
            end
          end
        end
        ST_REFILL: begin
          if (mem.MemAck) begin
            if (r_k == C_LAST) begin
              r_state <= ST_IDLE;
              r_k     <= '0;
              r_req   <= 1'b0;
            end else begin
              r_k    <= r_k + K_W'(1);
              r_addr <= r_addr + 32'd4;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem.MemReq       = r_req;
  assign mem.MemWb        = r_wb;
  assign mem.MemAddr      = r_addr;
  assign mem.MemWriteData = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_dcache.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_dcache
// Description : Directed self-checking bench for mem_stage_dcache with a
//               word memory model whose acknowledge can be immediate or
//               delayed by a fixed number of wait cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_dcache;
  import mem_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] AluResult, WriteData, Result;
  logic        MemRead, MemWrite, DStall;
  logic [2:0]  LS_op;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        MisalignErr;
`endif

  mem_stage_dcache_if bus ();

  mem_stage_dcache #(.NUM_LINES(64), .WORDS_PER_LINE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .AluResult (AluResult),
    .WriteData (WriteData),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .LS_op     (LS_op),
    .Result    (Result),
    .DStall    (DStall),
`ifdef MEM_MISALIGN_TRAP_EN
    .MisalignErr (MisalignErr),
`endif
    .mem       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  typedef struct packed {
    logic        wb;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic [31:0] mem [0:1023];
  logic        mem_init;
  int          ack_delay;
  int          wcnt;
  txn_t        log_q [$];

  assign bus.MemAck  = (ack_delay == 0) ? 1'b1 : (bus.MemReq && wcnt == ack_delay);
  assign bus.MemData = mem[bus.MemAddr[11:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE_0000 | 32'(i << 2);
      mem[10'h040] <= 32'hDEADBEEF;
      wcnt <= 0;
    end else begin
      if (!bus.MemReq || bus.MemAck) wcnt <= 0;
      else wcnt <= wcnt + 1;
      if (rst && bus.MemReq && bus.MemAck) begin
        log_q.push_back('{wb: bus.MemWb, addr: bus.MemAddr,
                          data: bus.MemWb ? bus.MemWriteData : bus.MemData});
        if (bus.MemWb) mem[bus.MemAddr[11:2]] <= bus.MemWriteData;
      end
    end
  end

  // ---------------- checking ----------------
  int tests_run;
  int tests_failed;
  int addr_changes;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Counts stalled cycles from the current (post-negedge) point until
  // DStall drops, tracking any address change during an ack wait.
  task automatic wait_stall(output int stalls);
    logic        p_req, p_ack;
    logic [31:0] p_addr;
    stalls = 0;
    while (DStall && stalls < 300) begin
      stalls++;
      p_req  = bus.MemReq;
      p_ack  = bus.MemAck;
      p_addr = bus.MemAddr;
      @(negedge clk); #1;
      if (p_req && !p_ack && bus.MemReq && bus.MemAddr !== p_addr) addr_changes++;
    end
    check("stall_timeout", {31'b0, DStall}, 32'h0);
  endtask

  task automatic access(input logic rd, input logic wr, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wd, output int stalls);
    @(negedge clk);
    MemRead   = rd;
    MemWrite  = wr;
    LS_op     = op;
    AluResult = addr;
    WriteData = wd;
    #1;
    wait_stall(stalls);
  endtask

  task automatic check_burst(input string tag, input int first, input logic wb,
                             input logic [31:0] base);
    for (int i = 0; i < 4; i++) begin
      if (first + i < log_q.size()) begin
        check({tag, "_addr"}, log_q[first + i].addr, base + 32'(4 * i));
        check({tag, "_dir"},  {31'b0, log_q[first + i].wb}, {31'b0, wb});
      end else begin
        check({tag, "_missing"}, 32'(log_q.size()), 32'(first + i + 1));
      end
    end
  endtask

  initial begin
    int st;
    tests_run    = 0;
    tests_failed = 0;
    addr_changes = 0;
    ack_delay    = 0;
    mem_init     = 1'b1;
    rst          = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    LS_op        = LS_LW;
    AluResult    = 32'h0000_1234;
    WriteData    = 32'h0;

    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    #1;
    check("rst_memreq", {31'b0, bus.MemReq}, 32'h0);
    check("rst_memwb",  {31'b0, bus.MemWb},  32'h0);
    check("rst_memaddr", bus.MemAddr, 32'h0);
    check("rst_memwdata", bus.MemWriteData, 32'h0);
    check("rst_dstall", {31'b0, DStall}, 32'h0);
    check("rst_result", Result, 32'h0000_1234);
    rst = 1'b1;

    // Both MemRead and MemWrite: no access
    access(1'b1, 1'b1, LS_LW, 32'h100, 32'h0, st);
    check("both_stall", 32'(st), 32'd0);
    check("both_result", Result, 32'h100);
    check("both_noreq", {31'b0, bus.MemReq}, 32'h0);

    // Cold clean miss
    log_q.delete();
    access(1'b1, 1'b0, LS_LW, 32'h100, 32'h0, st);
    check("cold_stall", 32'(st), 32'd5);
    check("cold_result", Result, 32'hDEADBEEF);
    check("cold_nreads", 32'(log_q.size()), 32'd4);
    check_burst("cold_rd", 0, 1'b0, 32'h100);
    check("cold_rd0_data", log_q[0].data, 32'hDEADBEEF);

    // Sub-word loads on the filled line
    access(1'b1, 1'b0, LS_LB, 32'h103, 32'h0, st);
    check("lb_stall", 32'(st), 32'd0);
    check("lb_result", Result, 32'hFFFFFFDE);
    access(1'b1, 1'b0, LS_LBU, 32'h103, 32'h0, st);
    check("lbu_result", Result, 32'h000000DE);
    access(1'b1, 1'b0, LS_LH, 32'h102, 32'h0, st);
    check("lh_result", Result, 32'hFFFFDEAD);
    access(1'b1, 1'b0, LS_LHU, 32'h102, 32'h0, st);
    check("lhu_stall", 32'(st), 32'd0);
    check("lhu_result", Result, 32'h0000DEAD);
    access(1'b1, 1'b0, LS_LBU, 32'h100, 32'h0, st);
    check("lbu0_result", Result, 32'h000000EF);

    // Store-byte hit
    log_q.delete();
    access(1'b0, 1'b1, LS_SB, 32'h101, 32'h0000_0012, st);
    check("sb_stall", 32'(st), 32'd0);
    check("sb_noreq", {31'b0, bus.MemReq}, 32'h0);
    access(1'b1, 1'b0, LS_LW, 32'h100, 32'h0, st);
    check("sb_lw_stall", 32'(st), 32'd0);
    check("sb_lw_result", Result, 32'hDEAD12EF);
    check("sb_no_txn", 32'(log_q.size()), 32'd0);

    // Dirty-victim miss: write-back then refill
    log_q.delete();
    access(1'b1, 1'b0, LS_LW, 32'h500, 32'h0, st);
    check("dirty_stall", 32'(st), 32'd9);
    check("dirty_ntxn", 32'(log_q.size()), 32'd8);
    check_burst("dirty_wb", 0, 1'b1, 32'h100);
    check("dirty_wb0_data", log_q[0].data, 32'hDEAD12EF);
    check("dirty_wb1_data", log_q[1].data, 32'hC0DE0104);
    check_burst("dirty_rf", 4, 1'b0, 32'h500);
    check("dirty_result", Result, 32'hC0DE0500);
    check("dirty_mem100", mem[10'h040], 32'hDEAD12EF);

    // Delayed acknowledge (3 wait cycles per word) on a clean miss
    ack_delay    = 3;
    addr_changes = 0;
    log_q.delete();
    access(1'b1, 1'b0, LS_LW, 32'h90C, 32'h0, st);
    check("slow_stall", 32'(st), 32'd17);
    check("slow_addr_stable", 32'(addr_changes), 32'd0);
    check("slow_ntxn", 32'(log_q.size()), 32'd4);
    check_burst("slow_rf", 0, 1'b0, 32'h900);
    check("slow_result", Result, 32'hC0DE090C);
    ack_delay = 0;

    // Reset during the second refill word
    @(negedge clk);
    AluResult = 32'h100;
    LS_op     = LS_LW;
    MemRead   = 1'b1;
    MemWrite  = 1'b0;
    #1;
    check("rm_miss", {31'b0, DStall}, 32'h1);
    @(negedge clk); #1;
    check("rm_req0", {31'b0, bus.MemReq}, 32'h1);
    check("rm_addr0", bus.MemAddr, 32'h100);
    @(negedge clk); #1;
    check("rm_addr1", bus.MemAddr, 32'h104);
    rst = 1'b0;
    @(negedge clk); #1;
    check("rm_req_dropped", {31'b0, bus.MemReq}, 32'h0);
    rst = 1'b1;
    log_q.delete();
    check("rm_miss_again", {31'b0, DStall}, 32'h1);
    wait_stall(st);
    check("rm_stall", 32'(st), 32'd5);
    check("rm_ntxn", 32'(log_q.size()), 32'd4);
    check_burst("rm_rf", 0, 1'b0, 32'h100);
    check("rm_result", Result, 32'hDEAD12EF);

`ifdef MEM_MISALIGN_TRAP_EN
    log_q.delete();
    access(1'b1, 1'b0, LS_LW, 32'h102, 32'h0, st);
    check("mis_err", {31'b0, MisalignErr}, 32'h1);
    check("mis_stall", 32'(st), 32'd0);
    check("mis_noreq", {31'b0, bus.MemReq}, 32'h0);
    check("mis_result", Result, 32'h102);
    @(negedge clk); #1;
    check("mis_no_txn", 32'(log_q.size()), 32'd0);
`endif

    @(negedge clk);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
